// File: rtl/virtual_network_net_to_core.sv
// Receive-side network interface for one virtual network: buffers router
// flits, reassembles HEADER/BODY/TAIL or HT flits into packet bodies and
// queues finished packets for the Cache Controller / Directory.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   enable            0 freezes reassembly (input buffer still accepts)
//   flit_valid        router presents flit_in this cycle
//   flit_in           flit_t: type, vc_id, destination, core dest, payload
//   vn_flit_credit    router may send next cycle (~buffer almost_full)
//   packet_valid      completed packet at head of queue
//   packet_body       head-of-queue packet body (0 while queue empty)
//   packet_consumed   core dequeues the head packet
//   vn_protocol_error sticky malformed-stream flag
//
// Optional build macro NI_VN_PROTOCOL_CHECK_EN enables vc_id checking and
// the sticky vn_protocol_error flag; without it the flag is tied to 0.

`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif

package vn_pkg;
   localparam int PAYLOAD_W = `PAYLOAD_W;

   typedef enum logic [1:0] {
      FLIT_HEADER = 2'd0,
      FLIT_BODY   = 2'd1,
      FLIT_TAIL   = 2'd2,
      FLIT_HT     = 2'd3
   } flit_type_t;

   typedef enum logic [1:0] {
      VC0 = 2'd0,
      VC1 = 2'd1,
      VC2 = 2'd2,
      VC3 = 2'd3
   } vc_id_t;

   typedef struct packed {
      flit_type_t             flit_type;
      vc_id_t                 vc_id;
      logic [3:0]             destination;
      logic [1:0]             core_destination;
      logic [PAYLOAD_W-1:0]   payload;
   } flit_t;
endpackage

module virtual_network_net_to_core
   import vn_pkg::*;
#(
   parameter vc_id_t VCID                       = VC0,
   parameter int     PACKET_BODY_SIZE           = 256,
   parameter int     FLIT_FIFO_SIZE             = 4,
   parameter int     FLIT_ALMOST_FULL_THRESHOLD = 1,
   parameter int     PACKET_FIFO_SIZE           = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        flit_valid,
   input  flit_t                       flit_in,
   output logic                        vn_flit_credit,
   output logic                        packet_valid,
   output logic [PACKET_BODY_SIZE-1:0] packet_body,
   input  logic                        packet_consumed,
   output logic                        vn_protocol_error
);

   localparam int FLIT_NUMB =
      (PACKET_BODY_SIZE + PAYLOAD_W - 1) / PAYLOAD_W;
   localparam int ASM_W = FLIT_NUMB * PAYLOAD_W;
   localparam int CNT_W = (FLIT_NUMB > 1) ? $clog2(FLIT_NUMB) : 1;
   localparam int IDX_W = (ASM_W > 1) ? $clog2(ASM_W) : 1;
   localparam int FA_W  = $clog2(FLIT_FIFO_SIZE);
   localparam int PA_W  = $clog2(PACKET_FIFO_SIZE);

   typedef enum logic {
      S_IDLE,
      S_ACCUM
   } state_t;

   // ---------------- flit buffer ----------------
   flit_t           r_fbuf [FLIT_FIFO_SIZE];
   logic [FA_W-1:0] r_fwr;
   logic [FA_W-1:0] r_frd;
   logic [FA_W:0]   r_fcnt;
   logic            w_fempty;
   logic            w_ffull;
   logic            w_fwr;
   logic            w_fpop;
   flit_t           w_head;

   assign w_fempty = (r_fcnt == '0);
   assign w_ffull  = (r_fcnt == (FA_W+1)'(FLIT_FIFO_SIZE));
   assign w_fwr    = flit_valid && !w_ffull;
   assign w_head   = r_fbuf[r_frd];

   // credit drops once free slots fall to the threshold
   assign vn_flit_credit =
      (int'(r_fcnt) + FLIT_ALMOST_FULL_THRESHOLD) < FLIT_FIFO_SIZE;

   always_ff @(posedge clk) begin
      if (w_fwr) r_fbuf[r_fwr] <= flit_in;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fwr  <= '0;
         r_frd  <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_fwr)  r_fwr <= r_fwr + FA_W'(1);
         if (w_fpop) r_frd <= r_frd + FA_W'(1);
         case ({w_fwr, w_fpop})
            2'b10:   r_fcnt <= r_fcnt + (FA_W+1)'(1);
            2'b01:   r_fcnt <= r_fcnt - (FA_W+1)'(1);
            default: ;
         endcase
      end
   end

   // ---------------- packet queue ----------------
   logic [PACKET_BODY_SIZE-1:0] r_pbuf [PACKET_FIFO_SIZE];
   logic [PA_W-1:0]             r_pwr;
   logic [PA_W-1:0]             r_prd;
   logic [PA_W:0]               r_pcnt;
   logic                        w_pempty;
   logic                        w_pfull;
   logic                        w_penq;
   logic                        w_pdeq;
   logic [PACKET_BODY_SIZE-1:0] w_pkt;

   assign w_pempty = (r_pcnt == '0);
   assign w_pfull  = (r_pcnt == (PA_W+1)'(PACKET_FIFO_SIZE));
   assign w_pdeq   = packet_consumed && !w_pempty;

   assign packet_valid = !w_pempty;
   assign packet_body  = w_pempty ? '0 : r_pbuf[r_prd];

   always_ff @(posedge clk) begin
      if (w_penq) r_pbuf[r_pwr] <= w_pkt;
   end

   // full is the registered count, so a same-cycle dequeue does not
   // make room for an enqueue until the next cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pwr  <= '0;
         r_prd  <= '0;
         r_pcnt <= '0;
      end else begin
         if (w_penq) r_pwr <= r_pwr + PA_W'(1);
         if (w_pdeq) r_prd <= r_prd + PA_W'(1);
         case ({w_penq, w_pdeq})
            2'b10:   r_pcnt <= r_pcnt + (PA_W+1)'(1);
            2'b01:   r_pcnt <= r_pcnt - (PA_W+1)'(1);
            default: ;
         endcase
      end
   end

   // ---------------- reassembly FSM ----------------
   state_t           r_state;
   state_t           w_state_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic [ASM_W-1:0] r_asm;
   logic [ASM_W-1:0] w_asm_nx;
   logic [IDX_W-1:0] w_base;
   logic             w_done;
   logic             w_err;
   logic             w_vc_ok;
   logic             w_last;
   logic             w_is_ht;
   logic             w_is_hdr;
   logic             w_is_tail;

`ifdef NI_VN_PROTOCOL_CHECK_EN
   assign w_vc_ok = (w_head.vc_id == VCID);
`else
   assign w_vc_ok = 1'b1;
`endif

   assign w_is_ht   = (w_head.flit_type == FLIT_HT);
   assign w_is_hdr  = (w_head.flit_type == FLIT_HEADER);
   assign w_is_tail = (w_head.flit_type == FLIT_TAIL);
   assign w_last    = (r_cnt == CNT_W'(FLIT_NUMB - 1));
   assign w_base    = IDX_W'(int'(r_cnt) * PAYLOAD_W);
   assign w_pkt     = w_asm_nx[PACKET_BODY_SIZE-1:0];

   // next state assumes the head flit is popped this cycle
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_asm_nx   = r_asm;
      w_done     = 1'b0;
      w_err      = 1'b0;
      priority case (1'b1)
         !w_vc_ok: begin
            w_err = 1'b1;
         end
         w_is_ht: begin
            w_err      = (r_state == S_ACCUM);
            w_asm_nx   = '0;
            w_asm_nx[PAYLOAD_W-1:0] = w_head.payload;
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
            w_done     = 1'b1;
         end
         w_is_hdr: begin
            w_err      = (r_state == S_ACCUM);
            w_asm_nx   = '0;
            w_asm_nx[PAYLOAD_W-1:0] = w_head.payload;
            w_cnt_nx   = CNT_W'(1);
            w_state_nx = S_ACCUM;
         end
         (r_state == S_IDLE): begin
            w_err = 1'b1;
         end
         w_is_tail: begin
            w_asm_nx[w_base +: PAYLOAD_W] = w_head.payload;
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
            w_done     = 1'b1;
         end
         w_last: begin
            w_err = 1'b1;
         end
         default: begin
            w_asm_nx[w_base +: PAYLOAD_W] = w_head.payload;
            w_cnt_nx = r_cnt + CNT_W'(1);
         end
      endcase
   end

   // a completing flit waits at the head while the packet queue is full
   assign w_fpop = enable && !w_fempty && (!w_done || !w_pfull);
   assign w_penq = w_fpop && w_done;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_asm   <= '0;
      end else if (w_fpop) begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_asm   <= w_asm_nx;
      end
   end

`ifdef NI_VN_PROTOCOL_CHECK_EN
   logic r_err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if ((w_fpop && w_err) || (flit_valid && w_ffull)) begin
         r_err <= 1'b1;
      end
   end

   assign vn_protocol_error = r_err;

   logic w_unused;
   assign w_unused = ^{w_head.destination, w_head.core_destination};
`else
   assign vn_protocol_error = 1'b0;

   logic w_unused;
   assign w_unused = ^{w_head.destination, w_head.core_destination,
                       w_head.vc_id, (w_head.vc_id == VCID), w_err};
`endif

endmodule

// File: tb/tb_virtual_network_net_to_core.sv
// Directed self-checking bench for virtual_network_net_to_core
// (PACKET_BODY_SIZE=256, 64-bit payload, 4-deep flit and packet FIFOs).
module tb_virtual_network_net_to_core;
   import vn_pkg::*;

   localparam int PBS = 256;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic           flit_valid;
   flit_t          flit_in;
   logic           vn_flit_credit;
   logic           packet_valid;
   logic [PBS-1:0] packet_body;
   logic           packet_consumed;
   logic           vn_protocol_error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   virtual_network_net_to_core #(
      .VCID                       (VC0),
      .PACKET_BODY_SIZE           (PBS),
      .FLIT_FIFO_SIZE             (4),
      .FLIT_ALMOST_FULL_THRESHOLD (1),
      .PACKET_FIFO_SIZE           (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .flit_valid        (flit_valid),
      .flit_in           (flit_in),
      .vn_flit_credit    (vn_flit_credit),
      .packet_valid      (packet_valid),
      .packet_body       (packet_body),
      .packet_consumed   (packet_consumed),
      .vn_protocol_error (vn_protocol_error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input flit_type_t t, input logic [63:0] p);
      flit_valid = 1'b1;
      flit_in = '{flit_type: t, vc_id: VC0, destination: 4'd0,
                  core_destination: 2'd0, payload: p};
      tick();
      flit_valid = 1'b0;
   endtask

   task automatic consume();
      packet_consumed = 1'b1;
      tick();
      packet_consumed = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      enable = 1'b1;
      flit_valid = 1'b0;
      flit_in = '0;
      packet_consumed = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (vn_flit_credit !== 1'b1) begin
         errors++;
         $display("FAIL reset_credit: got %b want 1", vn_flit_credit);
      end
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", packet_valid);
      end
      checks++;
      if (packet_body !== '0) begin
         errors++;
         $display("FAIL reset_body: got %h want 0", packet_body);
      end
      checks++;
      if (vn_protocol_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b want 0", vn_protocol_error);
      end
   endtask

   task automatic test_four_flit();
      logic [PBS-1:0] exp;
      exp = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
             64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
      drive(FLIT_HEADER, 64'hA0A0_0000_0000_0000);
      drive(FLIT_BODY,   64'hA1A1_0000_0000_0001);
      drive(FLIT_BODY,   64'hA2A2_0000_0000_0002);
      drive(FLIT_TAIL,   64'hA3A3_0000_0000_0003);
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL ff_valid_early: got %b want 0", packet_valid);
      end
      tick();
      checks++;
      if (packet_valid !== 1'b1) begin
         errors++;
         $display("FAIL ff_valid: got %b want 1", packet_valid);
      end
      checks++;
      if (packet_body !== exp) begin
         errors++;
         $display("FAIL ff_body: got %h want %h", packet_body, exp);
      end
      consume();
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL ff_drained: got %b want 0", packet_valid);
      end
   endtask

   task automatic test_ht();
      logic [PBS-1:0] ones;
      logic [PBS-1:0] exp;
      ones = '1;
      exp = '0;
      exp[63:0] = 64'h1234;
      drive(FLIT_HEADER, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(FLIT_BODY,   64'hFFFF_FFFF_FFFF_FFFF);
      drive(FLIT_BODY,   64'hFFFF_FFFF_FFFF_FFFF);
      drive(FLIT_TAIL,   64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      checks++;
      if (packet_body !== ones) begin
         errors++;
         $display("FAIL ht_prior: got %h want %h", packet_body, ones);
      end
      consume();
      drive(FLIT_HT, 64'h1234);
      tick();
      checks++;
      if (packet_valid !== 1'b1) begin
         errors++;
         $display("FAIL ht_valid: got %b want 1", packet_valid);
      end
      checks++;
      if (packet_body !== exp) begin
         errors++;
         $display("FAIL ht_body: got %h want %h", packet_body, exp);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [PBS-1:0] exp;
      for (int i = 1; i <= 6; i++) drive(FLIT_HT, 64'(i));
      checks++;
      if (vn_flit_credit !== 1'b1) begin
         errors++;
         $display("FAIL bp_credit_hi: got %b want 1", vn_flit_credit);
      end
      drive(FLIT_HT, 64'd7);
      checks++;
      if (vn_flit_credit !== 1'b0) begin
         errors++;
         $display("FAIL bp_credit_lo: got %b want 0", vn_flit_credit);
      end
      tick();
      tick();
      checks++;
      if (vn_flit_credit !== 1'b0) begin
         errors++;
         $display("FAIL bp_credit_hold: got %b want 0", vn_flit_credit);
      end
      for (int i = 1; i <= 7; i++) begin
         for (int w = 0; w < 10 && !packet_valid; w++) tick();
         exp = '0;
         exp[63:0] = 64'(i);
         checks++;
         if (packet_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_%0d: got %b want 1", i, packet_valid);
         end
         checks++;
         if (packet_body !== exp) begin
            errors++;
            $display("FAIL bp_body_%0d: got %h want %h",
                     i, packet_body, exp);
         end
         consume();
      end
      tick();
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got %b want 0", packet_valid);
      end
      checks++;
      if (vn_flit_credit !== 1'b1) begin
         errors++;
         $display("FAIL bp_credit_back: got %b want 1", vn_flit_credit);
      end
   endtask

   task automatic test_enable();
      logic [PBS-1:0] exp;
      logic [PBS-1:0] exp2;
      exp = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
      exp2 = '0;
      exp2[63:0] = 64'h5555;
      drive(FLIT_HEADER, 64'h1111);
      drive(FLIT_BODY,   64'h2222);
      drive(FLIT_BODY,   64'h3333);
      enable = 1'b0;
      drive(FLIT_TAIL,   64'h4444);
      checks++;
      if (vn_flit_credit !== 1'b1) begin
         errors++;
         $display("FAIL en_credit_2: got %b want 1", vn_flit_credit);
      end
      drive(FLIT_HT,     64'h5555);
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (vn_flit_credit !== 1'b0) begin
         errors++;
         $display("FAIL en_credit_3: got %b want 0", vn_flit_credit);
      end
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_frozen: got %b want 0", packet_valid);
      end
      enable = 1'b1;
      tick();
      tick();
      checks++;
      if (packet_body !== exp) begin
         errors++;
         $display("FAIL en_body: got %h want %h", packet_body, exp);
      end
      consume();
      checks++;
      if (packet_body !== exp2) begin
         errors++;
         $display("FAIL en_body_ht: got %h want %h", packet_body, exp2);
      end
      consume();
      checks++;
      if (vn_flit_credit !== 1'b1) begin
         errors++;
         $display("FAIL en_credit_end: got %b want 1", vn_flit_credit);
      end
   endtask

   task automatic test_reset_mid();
      logic [PBS-1:0] exp;
      exp = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
      drive(FLIT_HT,     64'h9999);
      drive(FLIT_HEADER, 64'hDEAD);
      drive(FLIT_BODY,   64'hBEEF);
      checks++;
      if (packet_valid !== 1'b1) begin
         errors++;
         $display("FAIL rm_pre_valid: got %b want 1", packet_valid);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_valid: got %b want 0", packet_valid);
      end
      checks++;
      if (packet_body !== '0) begin
         errors++;
         $display("FAIL rm_body: got %h want 0", packet_body);
      end
      checks++;
      if (vn_flit_credit !== 1'b1) begin
         errors++;
         $display("FAIL rm_credit: got %b want 1", vn_flit_credit);
      end
      tick();
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_no_stale: got %b want 0", packet_valid);
      end
      drive(FLIT_HEADER, 64'hC0);
      drive(FLIT_BODY,   64'hC1);
      drive(FLIT_BODY,   64'hC2);
      drive(FLIT_TAIL,   64'hC3);
      tick();
      checks++;
      if (packet_body !== exp) begin
         errors++;
         $display("FAIL rm_body_new: got %h want %h", packet_body, exp);
      end
      consume();
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_single: got %b want 0", packet_valid);
      end
   endtask

`ifdef NI_VN_PROTOCOL_CHECK_EN
   task automatic test_protocol();
      logic [PBS-1:0] exp;
      exp = '0;
      exp[63:0] = 64'h77;
      checks++;
      if (vn_protocol_error !== 1'b0) begin
         errors++;
         $display("FAIL pe_clear: got %b want 0", vn_protocol_error);
      end
      drive(FLIT_TAIL, 64'hBAD);
      tick();
      checks++;
      if (vn_protocol_error !== 1'b1) begin
         errors++;
         $display("FAIL pe_set: got %b want 1", vn_protocol_error);
      end
      checks++;
      if (packet_valid !== 1'b0) begin
         errors++;
         $display("FAIL pe_dropped: got %b want 0", packet_valid);
      end
      drive(FLIT_HT, 64'h77);
      tick();
      checks++;
      if (packet_body !== exp) begin
         errors++;
         $display("FAIL pe_ht_body: got %h want %h", packet_body, exp);
      end
      checks++;
      if (vn_protocol_error !== 1'b1) begin
         errors++;
         $display("FAIL pe_sticky: got %b want 1", vn_protocol_error);
      end
      consume();
   endtask
`endif

   initial begin
      test_reset();
      test_four_flit();
      test_ht();
      test_back_to_back();
      test_enable();
      test_reset_mid();
`ifdef NI_VN_PROTOCOL_CHECK_EN
      test_protocol();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
